// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants and the decoded-bundle type carried from decode to the ALU.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic op_add, op_sub, op_and, op_or, op_xor, op_sll, op_srl, op_sra;
        logic op_eq, op_ne, op_lt, op_ge, op_ltu, op_geu, op_rs2_imm;
    } alu_ops_t;

    typedef struct packed {
        alu_ops_t    ops;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } dec_bundle_t;

endpackage

// File: rtl/rv32i_alu_decode_comb.sv
// Combinational RV32I decode of one instruction word into ALU strobes, operand-B select and immediate.
module rv32i_alu_decode_comb
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output dec_bundle_t dec
);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};

    always_comb begin
        dec     = '0;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.rd  = instr[11:7];
        case (opc)
            // R-type carries the I-immediate field so imm bit 31 still tracks instr[31]
            OPC_OP: begin
                dec.imm = imm_i;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  dec.ops.op_add = 1'b1;
                        F3_SLL:  dec.ops.op_sll = 1'b1;
                        F3_SLT:  dec.ops.op_lt  = 1'b1;
                        F3_SLTU: dec.ops.op_ltu = 1'b1;
                        F3_XOR:  dec.ops.op_xor = 1'b1;
                        F3_SR:   dec.ops.op_srl = 1'b1;
                        F3_OR:   dec.ops.op_or  = 1'b1;
                        default: dec.ops.op_and = 1'b1;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    dec.ops.op_sub = 1'b1;
                end else if (f7 == F7_ALT && f3 == F3_SR) begin
                    dec.ops.op_sra = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.use_imm = 1'b1;
                dec.imm     = imm_i;
                case (f3)
                    F3_ADD:  dec.ops.op_add = 1'b1;
                    F3_SLT:  dec.ops.op_lt  = 1'b1;
                    F3_SLTU: dec.ops.op_ltu = 1'b1;
                    F3_XOR:  dec.ops.op_xor = 1'b1;
                    F3_OR:   dec.ops.op_or  = 1'b1;
                    F3_AND:  dec.ops.op_and = 1'b1;
                    F3_SLL: begin
                        if (f7 == F7_BASE) dec.ops.op_sll = 1'b1;
                        else               dec.illegal    = 1'b1;
                    end
                    default: begin
                        if      (f7 == F7_BASE) dec.ops.op_srl = 1'b1;
                        else if (f7 == F7_ALT)  dec.ops.op_sra = 1'b1;
                        else                    dec.illegal    = 1'b1;
                    end
                endcase
            end
            OPC_BRANCH: begin
                dec.imm = imm_b;
                case (f3)
                    F3_BEQ:  dec.ops.op_eq  = 1'b1;
                    F3_BNE:  dec.ops.op_ne  = 1'b1;
                    F3_BLT:  dec.ops.op_lt  = 1'b1;
                    F3_BGE:  dec.ops.op_ge  = 1'b1;
                    F3_BLTU: dec.ops.op_ltu = 1'b1;
                    F3_BGEU: dec.ops.op_geu = 1'b1;
                    default: dec.illegal    = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.ops.op_add = 1'b1;
                dec.use_imm    = 1'b1;
                dec.imm        = imm_i;
            end
            OPC_STORE: begin
                dec.ops.op_add = 1'b1;
                dec.use_imm    = 1'b1;
                dec.imm        = imm_s;
            end
            OPC_LUI: begin
                dec.ops.op_rs2_imm = 1'b1;
                dec.use_imm        = 1'b1;
                dec.imm            = imm_u;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.ops     = '0;
            dec.imm     = '0;
            dec.use_imm = 1'b0;
        end
    end
endmodule

// File: rtl/rv32i_alu_decode.sv
// Registered decode stage: decodes on the input side, then a two-entry output/skid buffer.
module rv32i_alu_decode
    import rv32i_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    output logic        instr_ready_o,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic        op_add_o, op_sub_o, op_and_o, op_or_o,
    output logic        op_xor_o, op_sll_o, op_srl_o, op_sra_o,
    output logic        op_eq_o, op_ne_o, op_lt_o, op_ge_o, op_ltu_o, op_geu_o,
    output logic        op_rs2_imm_o,
    output logic        use_imm_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        illegal_o
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} buf_state_e;

    buf_state_e  state_q;
    dec_bundle_t dec_in, out_q, skid_q;
    logic        valid_q, ready_q, push, pop;

    rv32i_alu_decode_comb u_comb (.instr(instr_i), .dec(dec_in));

    assign push = instr_valid_i & ready_q;
    assign pop  = valid_q & dec_ready_i;

    // Ready and valid are registered alongside the state they depend on.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (push) begin
                    out_q   <= dec_in;
                    state_q <= FULL;
                    valid_q <= 1'b1;
                end
                FULL: begin
                    if (push && pop) begin
                        out_q <= dec_in;
                    end else if (push) begin
                        skid_q  <= dec_in;
                        state_q <= SKID;
                        ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                SKID: if (pop) begin
                    out_q   <= skid_q;
                    state_q <= FULL;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready_o = ready_q;
    assign dec_valid_o   = valid_q;
    assign op_add_o      = out_q.ops.op_add;
    assign op_sub_o      = out_q.ops.op_sub;
    assign op_and_o      = out_q.ops.op_and;
    assign op_or_o       = out_q.ops.op_or;
    assign op_xor_o      = out_q.ops.op_xor;
    assign op_sll_o      = out_q.ops.op_sll;
    assign op_srl_o      = out_q.ops.op_srl;
    assign op_sra_o      = out_q.ops.op_sra;
    assign op_eq_o       = out_q.ops.op_eq;
    assign op_ne_o       = out_q.ops.op_ne;
    assign op_lt_o       = out_q.ops.op_lt;
    assign op_ge_o       = out_q.ops.op_ge;
    assign op_ltu_o      = out_q.ops.op_ltu;
    assign op_geu_o      = out_q.ops.op_geu;
    assign op_rs2_imm_o  = out_q.ops.op_rs2_imm;
    assign use_imm_o     = out_q.use_imm;
    assign imm_o         = out_q.imm;
    assign rs1_o         = out_q.rs1;
    assign rs2_o         = out_q.rs2;
    assign rd_o          = out_q.rd;
    assign illegal_o     = out_q.illegal;
endmodule
